// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: byte-level controller for an HD44780-style character LCD.
// Runs the power-up / 4-bit init sequence, then forwards host command and
// character bytes to the nibble sender one at a time while tracking the cursor.
// Optional feature: define LCD_AUTOWRAP_EN to re-address DDRAM after a line wrap.
module lcd_char_ctrl #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned CLEAR_CYCLES   = 100000,
  parameter int unsigned COLS           = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oWriteBegin,
  output logic [7:0] oData,
  input  logic       iWriteDone,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [4:0] oCursor
);

  localparam logic [3:0] ColLast = 4'(COLS - 1);

  typedef enum logic [3:0] {
    StPwrupWait,
    StInitIssue,
    StInitWait,
    StDelay,
    StIdle,
    StIssue,
    StXferWait
`ifdef LCD_AUTOWRAP_EN
    ,
    StWrapIssue,
    StWrapWait
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  k_q, k_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        line_q, line_d;
  logic [3:0]  col_q, col_d;
  logic        init_done_q, init_done_d;

  // Init ROM: 8-bit mode wake-ups folded into 0x33/0x32, then 4-bit setup.
  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h33;
      3'd1:    b = 8'h32;
      3'd2:    b = 8'h28;
      3'd3:    b = 8'h06;
      3'd4:    b = 8'h0C;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StPwrupWait;
      cnt_q       <= '0;
      k_q         <= '0;
      data_q      <= '0;
      rs_q        <= 1'b0;
      line_q      <= 1'b0;
      col_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      line_q      <= line_d;
      col_q       <= col_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic; oData/oLCD_RS are loaded on entry to an issue state so
  // they are already stable in the oWriteBegin cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    data_d      = data_q;
    rs_d        = rs_q;
    line_d      = line_q;
    col_d       = col_q;
    init_done_d = init_done_q;

    case (state_q)
      StPwrupWait: begin
        if (cnt_q == POWERUP_CYCLES - 1) begin
          cnt_d   = '0;
          k_d     = '0;
          data_d  = init_rom(3'd0);
          rs_d    = 1'b0;
          state_d = StInitIssue;
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      StInitIssue: state_d = StInitWait;
      StInitWait: begin
        if (iWriteDone) begin
          if (k_q < 3'd5) begin
            k_d     = k_q + 3'd1;
            data_d  = init_rom(k_q + 3'd1);
            state_d = StInitIssue;
          end else begin
            cnt_d   = '0;
            state_d = StDelay;
          end
        end
      end
      StDelay: begin
        if (cnt_q == CLEAR_CYCLES - 1) begin
          cnt_d       = '0;
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      StIdle: begin
        if (iValid) begin
          data_d  = iData;
          rs_d    = iRS;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StXferWait;
      StXferWait: begin
        if (iWriteDone) begin
          state_d = StIdle;
          if (rs_q) begin
            if (col_q == ColLast) begin
              col_d  = '0;
              line_d = ~line_q;
`ifdef LCD_AUTOWRAP_EN
              data_d  = {1'b1, ~line_q, 6'b0};
              rs_d    = 1'b0;
              state_d = StWrapIssue;
`endif
            end else begin
              col_d = col_q + 4'd1;
            end
          end else if (data_q == 8'h01 || data_q == 8'h02) begin
            // Clear/home need the long execution wait before the next byte.
            line_d  = 1'b0;
            col_d   = '0;
            cnt_d   = '0;
            state_d = StDelay;
          end else if (data_q[7]) begin
            line_d = data_q[6];
            col_d  = data_q[3:0];
          end
        end
      end
`ifdef LCD_AUTOWRAP_EN
      StWrapIssue: state_d = StWrapWait;
      StWrapWait: begin
        if (iWriteDone) state_d = StIdle;
      end
`endif
      default: state_d = StPwrupWait;
    endcase
  end

  // Outputs decoded from state; begin pulse lasts exactly the one issue cycle.
  always_comb begin
    oReady      = (state_q == StIdle);
    oWriteBegin = (state_q == StInitIssue) || (state_q == StIssue);
`ifdef LCD_AUTOWRAP_EN
    if (state_q == StWrapIssue) oWriteBegin = 1'b1;
`endif
    oInitDone = init_done_q;
    oData     = data_q;
    oLCD_RS   = rs_q;
    oLCD_RW   = 1'b0;
    oCursor   = {line_q, col_q};
  end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Self-checking bench for lcd_char_ctrl: scoreboard of expected LCD writes and
// cursor values, fed by a reference model of the cursor rules.
`timescale 1ns/1ps
module tb_lcd_char_ctrl;

  localparam int unsigned PwrUp   = 100;
  localparam int unsigned ClrCyc  = 50;
  localparam int unsigned Cols    = 16;
  localparam int unsigned DoneLat = 20;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iValid = 1'b0;
  logic       iRS = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iWriteDone = 1'b0;
  logic       oReady, oInitDone, oWriteBegin, oLCD_RS, oLCD_RW;
  logic [7:0] oData;
  logic [4:0] oCursor;

  lcd_char_ctrl #(
    .POWERUP_CYCLES(PwrUp),
    .CLEAR_CYCLES  (ClrCyc),
    .COLS          (Cols)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iValid     (iValid),
    .iRS        (iRS),
    .iData      (iData),
    .oReady     (oReady),
    .oInitDone  (oInitDone),
    .oWriteBegin(oWriteBegin),
    .oData      (oData),
    .iWriteDone (iWriteDone),
    .oLCD_RS    (oLCD_RS),
    .oLCD_RW    (oLCD_RW),
    .oCursor    (oCursor)
  );

  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [4:0] exp_cur[$];
  int         tests = 0;
  int         fails = 0;
  int         pulses = 0;
  int unsigned last_done_edge = 0;
  int         m_line = 0;
  int         m_col = 0;
`ifdef LCD_AUTOWRAP_EN
  localparam int WrapExtra = 1;
`else
  localparam int WrapExtra = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input logic rs, input logic [7:0] d);
    wr_t w;
    w.rs   = rs;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_init();
    push_wr(1'b0, 8'h33);
    push_wr(1'b0, 8'h32);
    push_wr(1'b0, 8'h28);
    push_wr(1'b0, 8'h06);
    push_wr(1'b0, 8'h0C);
    push_wr(1'b0, 8'h01);
    m_line = 0;
    m_col  = 0;
    exp_cur.push_back(5'h00);
  endtask

  // Reference model: what the LCD sees and where the cursor ends up per request.
  task automatic model(input logic rs, input logic [7:0] d);
    logic [7:0] wrap_cmd;
    push_wr(rs, d);
    if (rs) begin
      m_col++;
      if (m_col == Cols) begin
        m_col  = 0;
        m_line = 1 - m_line;
        wrap_cmd = (m_line == 1) ? 8'hC0 : 8'h80;
        if (WrapExtra == 1) push_wr(1'b0, wrap_cmd);
      end
    end else if (d == 8'h01 || d == 8'h02) begin
      m_line = 0;
      m_col  = 0;
    end else if (d[7]) begin
      m_line = int'(d[6]);
      m_col  = int'(d[3:0]);
    end
    exp_cur.push_back(5'(m_line * 16 + m_col));
  endtask

  // Write monitor: every begin pulse must match the head of the expected queue.
  always @(negedge Clock) begin
    wr_t e;
    if (!Reset && oWriteBegin) begin
      pulses++;
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got rs=%0b data=0x%02h, expected no write", oLCD_RS,
                 oData);
      end else begin
        e = exp_wr.pop_front();
        check("write_data", 32'(oData), 32'(e.data));
        check("write_rs", 32'(oLCD_RS), 32'(e.rs));
        check("lcd_rw", 32'(oLCD_RW), 32'd0);
      end
    end
  end

  // Cursor monitor: each return to ready is compared with the model's cursor.
  logic ready_prev = 1'b0;
  always @(negedge Clock) begin
    if (Reset) begin
      ready_prev <= 1'b0;
    end else begin
      if (oReady && !ready_prev) begin
        if (exp_cur.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_ready: got cursor 0x%02h, expected no ready", oCursor);
        end else begin
          check("cursor", 32'(oCursor), 32'(exp_cur.pop_front()));
        end
      end
      ready_prev <= oReady;
    end
  end

  // Nibble-sender model: done pulse 20 cycles after each begin; data must hold.
  initial begin
    logic [7:0] held;
    bit         stable;
    bit         aborted;
    @(negedge Clock);
    forever begin
      if (!Reset && oWriteBegin) begin
        held    = oData;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < DoneLat; i++) begin
          @(negedge Clock);
          if (Reset) begin
            aborted = 1'b1;
            break;
          end
          if (oData !== held) stable = 1'b0;
        end
        if (!aborted) begin
          check("data_stable", 32'(stable), 32'd1);
          iWriteDone     = 1'b1;
          last_done_edge = cyc + 1;
          @(negedge Clock);
          iWriteDone = 1'b0;
        end
      end else begin
        @(negedge Clock);
      end
    end
  end

  task automatic wait_ready(input string name, input int max);
    int n = 0;
    while (!oReady && n < max) begin
      @(negedge Clock);
      n++;
    end
    if (!oReady) begin
      tests++;
      fails++;
      $display("FAIL %s: got oReady=0 after %0d cycles, expected 1", name, max);
    end
  endtask

  task automatic send(input logic rs, input logic [7:0] d, input bit hold);
    model(rs, d);
    iRS    = rs;
    iData  = d;
    iValid = 1'b1;
    wait_ready("accept_timeout", 2000);
    @(negedge Clock);
    if (!hold) iValid = 1'b0;
    check("begin_after_accept", 32'(oWriteBegin), 32'd1);
    check("ready_low_after_accept", 32'(oReady), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(oReady), 32'd0);
    check({tag, "_initdone"}, 32'(oInitDone), 32'd0);
    check({tag, "_begin"}, 32'(oWriteBegin), 32'd0);
    check({tag, "_data"}, 32'(oData), 32'd0);
    check({tag, "_rs"}, 32'(oLCD_RS), 32'd0);
    check({tag, "_rw"}, 32'(oLCD_RW), 32'd0);
    check({tag, "_cursor"}, 32'(oCursor), 32'd0);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!oInitDone && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    if (!oInitDone) begin
      tests++;
      fails++;
      $display("FAIL %s: got oInitDone=0 after 3000 cycles, expected 1", name);
    end else begin
      check({name, "_latency"}, cyc - last_done_edge, ClrCyc);
    end
  endtask

  initial begin
    int p0;
    logic [7:0] d;
    int unsigned r;

    push_init();
    repeat (3) @(negedge Clock);
    check_reset_values("por");
    Reset = 1'b0;

    wait_init("init");
    check("init_pulses", 32'(pulses), 32'd6);
    check("init_queue_empty", 32'(exp_wr.size()), 32'd0);

    // Single character after init.
    send(1'b1, 8'h41, 1'b0);
    wait_ready("char_ready", 500);
    check("cursor_after_A", 32'(oCursor), 32'h01);

    // Sixteen characters from home: wraps to line 1.
    send(1'b0, 8'h80, 1'b0);
    wait_ready("home_ready", 500);
    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 8'($urandom_range(8'h20, 8'h7E)), 1'b0);
      wait_ready("row_ready", 500);
    end
    check("row_pulses", 32'(pulses - p0), 32'(16 + WrapExtra));
    check("cursor_after_wrap", 32'(oCursor), 32'h10);

    // Clear from 0x13: cursor home and long busy window.
    send(1'b0, 8'hC3, 1'b0);
    wait_ready("ddram_ready", 500);
    check("cursor_set", 32'(oCursor), 32'h13);
    send(1'b0, 8'h01, 1'b0);
    wait_ready("clear_ready", 500);
    check("clear_busy", cyc - last_done_edge, ClrCyc);
    check("cursor_after_clear", 32'(oCursor), 32'h00);

    // iValid held through the whole transfer: only one accept.
    p0 = pulses;
    send(1'b1, 8'h55, 1'b1);
    wait_ready("hold_ready", 500);
    iValid = 1'b0;
    repeat (5) @(negedge Clock);
    check("hold_pulses", 32'(pulses - p0), 32'd1);

    // Randomised mix of commands and characters.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        send(1'b1, 8'($urandom_range(8'h20, 8'h7E)), 1'b0);
      end else begin
        r = $urandom_range(0, 5);
        case (r)
          0: d = 8'h01;
          1: d = 8'h02;
          2: d = 8'h80 | 8'($urandom_range(0, 255) & 32'h4F);
          3: d = 8'h06;
          4: d = 8'h0C;
          default: d = 8'h10;
        endcase
        send(1'b0, d, 1'b0);
      end
      wait_ready("rand_ready", 500);
    end

    // Reset in the middle of a character transfer.
    p0 = pulses;
    send(1'b1, 8'h5A, 1'b0);
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_reset_values("midreset");
    exp_wr.delete();
    exp_cur.delete();
    push_init();
    @(negedge Clock);
    Reset = 1'b0;
    wait_init("reinit");
    check("reinit_pulses", 32'(pulses - p0), 32'd7);

    send(1'b1, 8'h42, 1'b0);
    wait_ready("final_ready", 500);
    repeat (5) @(negedge Clock);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("cur_queue_empty", 32'(exp_cur.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
